modn_event_fsm: RTL
===================

Name: modn_event_fsm

Overview:
- Parametrised successor to the fixed 5-state ones-counting FSM: counts qualified input events modulo N_STATES.
- Adds a runtime-programmable match state, selectable event mode (level or edge, either polarity), enable, synchronous clear, a wrap pulse and a saturating wrap counter.
- Used as a small sequence/occurrence detector in front of control logic that needs "every Nth event" or "at count K" indications.

Parameters:
- N_STATES, 5, number of count states (legal range 2..256); the state wraps N_STATES-1 -> 0.
- SW, $clog2(N_STATES), state/target width (derived; do not override).
- WCW, 16, width of the saturating wrap counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  event qualification enable; when 0, the state holds.
- CLR  input  1  synchronous clear of state, MATCH and WRAP_CNT.
- MODE  input  2  event select: 00 = IN high, 01 = IN low, 10 = IN rising edge, 11 = IN falling edge.
- IN  input  1  event input; synchronous to CLK.
- TARGET  input  SW  state value at which MATCH asserts.
- STATE  output  SW  current count state.
- MATCH  output  1  registered: high for the cycle after a cycle in which STATE == TARGET.
- WRAP  output  1  registered one-cycle pulse, high for the cycle after a qualified event at state N_STATES-1.
- WRAP_CNT  output  WCW  number of wraps since reset/clear; saturates at all-ones.

Behaviour:
- Reset (RST=1 at the clock edge): STATE=0, MATCH=0, WRAP=0, WRAP_CNT=0, IN_d=0.
- Priority at each edge: RST > CLR > counting.
- IN_d is a registered copy of IN. It updates every non-reset cycle, including when EN=0 or CLR=1.
- Event qualification (combinational): ev = EN & f(MODE), where f is
  - 00: IN
  - 01: ~IN
  - 10: IN & ~IN_d
  - 11: ~IN & IN_d
- State transition:
  - if ev: STATE <= (STATE == N_STATES-1) ? 0 : STATE+1.
  - else STATE holds.
  - Illegal STATE values (>= N_STATES, reachable only for non-power-of-2 N_STATES) go to 0 on the next edge, regardless of ev.
- MATCH <= (STATE == TARGET), using the pre-edge STATE, so it lags STATE by one cycle.
  - TARGET >= N_STATES: MATCH never asserts.
  - A TARGET change takes effect on the next edge.
- WRAP <= ev & (STATE == N_STATES-1); otherwise 0.
- WRAP_CNT increments on the same condition and holds at 2^WCW-1 once there.
- CLR=1: STATE=0, MATCH=0, WRAP=0, WRAP_CNT=0 at that edge. A coincident event is discarded. The post-clear STATE=0 can raise MATCH on the following edge if TARGET=0.
- EN=0: STATE, WRAP_CNT hold and WRAP=0. MATCH keeps tracking STATE == TARGET.
- MODE change: takes effect the same cycle. An edge straddling the change is judged with the new MODE against IN_d.
- Reset mid-count: all state is lost and counting restarts from 0; no partial wrap is recorded.
- With N_STATES=5, TARGET=4, MODE=00, EN=1, CLR=0, the block matches the legacy 5-state FSM cycle for cycle.

Decomposition:
- Shared package modn_event_pkg holds:
  - MODE encodings: MODE_LVL_HI, MODE_LVL_LO, MODE_RISE, MODE_FALL.
  - Legal N_STATES bounds, checked at elaboration.
- One natural sub-module: modn_event_qual. It contains IN_d, the MODE mux and EN gating, and outputs ev.
- The counter, MATCH, WRAP and WRAP_CNT stay in the top.

Test Plan:
1. Legacy equivalence: N_STATES=5, TARGET=4, MODE=00, EN=1, IN=1 for 12 cycles after reset.
   - STATE goes 1,2,3,4,0,1,2,3,4,0,1,2.
   - MATCH is high exactly in the cycles after STATE=4.
   - WRAP pulses twice; WRAP_CNT=2.
2. Edge mode: MODE=10, IN toggles 0/1 every 2 cycles for 20 cycles, starting with IN=0 for 2 cycles.
   - STATE advances once per rising edge, reaching 0 after 5 rising edges.
   - Holding IN=1 for 6 cycles produces no further advance.
3. Falling-edge and low-level modes: MODE=11 then MODE=01 with the same IN pattern.
   - MODE=11: advances only on 1->0 transitions.
   - MODE=01: advances every cycle IN=0.
4. EN and CLR: count to STATE=3, EN=0 for 4 cycles, then CLR=1 together with IN=1, EN=1.
   - STATE holds at 3 during EN=0.
   - After CLR, STATE=0, WRAP_CNT=0, and the coincident event is dropped.
   - With TARGET=0, MATCH=1 on the following cycle.
5. Out-of-range TARGET and non-power-of-2 width: N_STATES=6, TARGET=7, 30 level-high events.
   - MATCH stays 0.
   - STATE never exceeds 5.
   - WRAP_CNT=5.
6. Saturation and mid-count reset: WCW=2, N_STATES=2, 20 events.
   - WRAP_CNT saturates at 3.
   - RST asserted while STATE=1 gives STATE=0, WRAP_CNT=0, MATCH=0 next cycle.

Source files
------------

// File: rtl/modn_event_pkg.sv
// Shared definitions for the modulo-N event counter: event-mode encodings and legal N_STATES range.
// Purely declarative; no logic, no latency.
package modn_event_pkg;

    typedef enum logic [1:0] {
        MODE_LVL_HI = 2'b00,
        MODE_LVL_LO = 2'b01,
        MODE_RISE   = 2'b10,
        MODE_FALL   = 2'b11
    } mode_e;

    localparam int N_STATES_MIN = 2;
    localparam int N_STATES_MAX = 256;

    function automatic bit n_states_legal(input int n);
        return (n >= N_STATES_MIN) && (n <= N_STATES_MAX);
    endfunction

endpackage

// File: rtl/modn_event_qual.sv
// Event qualifier: selects level/edge of either polarity on in_sig and gates it with en.
// ev is combinational from in_sig (edge history adds one flop); no backpressure.
module modn_event_qual
    import modn_event_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       in_sig,
    output logic       ev
);

    logic in_d_q;
    logic in_d_d;
    logic sel;

    // History follows the input every cycle, independent of en, so edges are never stale.
    always_comb begin
        in_d_d = in_sig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_d_q <= 1'b0;
        end else begin
            in_d_q <= in_d_d;
        end
    end

    always_comb begin
        sel = 1'b0;
        case (mode)
            MODE_LVL_HI: sel = in_sig;
            MODE_LVL_LO: sel = ~in_sig;
            MODE_RISE:   sel = in_sig & ~in_d_q;
            MODE_FALL:   sel = ~in_sig & in_d_q;
            default:     sel = 1'b0;
        endcase
        ev = en & sel;
    end

endmodule

// File: rtl/modn_event_fsm.sv
// Counts qualified events modulo N_STATES with registered match, wrap pulse and saturating wrap count.
// MATCH/WRAP/WRAP_CNT register one cycle after the deciding state/event; no backpressure.
module modn_event_fsm
    import modn_event_pkg::*;
#(
    parameter int N_STATES = 5,
    parameter int SW       = $clog2(N_STATES),
    parameter int WCW      = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic           CLR,
    input  logic [1:0]     MODE,
    input  logic           IN,
    input  logic [SW-1:0]  TARGET,
    output logic [SW-1:0]  STATE,
    output logic           MATCH,
    output logic           WRAP,
    output logic [WCW-1:0] WRAP_CNT
);

    if (!n_states_legal(N_STATES)) begin : g_bad_n_states
        $error("modn_event_fsm: N_STATES must be within 2..256");
    end

    localparam logic [SW-1:0] LAST = SW'(N_STATES - 1);

    logic           ev;
    logic [SW-1:0]  state_q, state_d;
    logic           match_q, match_d;
    logic           wrap_q, wrap_d;
    logic [WCW-1:0] wrap_cnt_q, wrap_cnt_d;
    logic           state_legal;
    logic           target_legal;
    logic           at_last;

    modn_event_qual u_qual (
        .clk    (CLK),
        .rst    (RST),
        .en     (EN),
        .mode   (MODE),
        .in_sig (IN),
        .ev     (ev)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= '0;
            match_q    <= 1'b0;
            wrap_q     <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            wrap_q     <= wrap_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    // Illegal encodings only exist when N_STATES is not a power of two.
    always_comb begin
        state_legal  = int'(state_q) < N_STATES;
        target_legal = int'(TARGET) < N_STATES;
        at_last      = (state_q == LAST);

        state_d    = state_q;
        match_d    = (state_q == TARGET) && target_legal;
        wrap_d     = 1'b0;
        wrap_cnt_d = wrap_cnt_q;

        if (CLR) begin
            state_d    = '0;
            match_d    = 1'b0;
            wrap_cnt_d = '0;
        end else if (!state_legal) begin
            state_d = '0;
        end else if (ev) begin
            state_d = at_last ? '0 : state_q + 1'b1;
            wrap_d  = at_last;
            if (at_last && (wrap_cnt_q != '1)) begin
                wrap_cnt_d = wrap_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        STATE    = state_q;
        MATCH    = match_q;
        WRAP     = wrap_q;
        WRAP_CNT = wrap_cnt_q;
    end

endmodule
